// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size encodings, memory map constants
// and a helper returning the byte count of an access.
package mem_pkg;

  typedef enum logic [1:0] {
    ACC_BYTE = 2'b00,
    ACC_HALF = 2'b01,
    ACC_WORD = 2'b10,
    ACC_RSVD = 2'b11
  } acc_e;

  localparam logic [31:0] MEM_BASE  = 32'h8002_0000;
  localparam int unsigned MEM_DEPTH = 1048576;

  // Reserved size reports 1 so range math never underflows;
  // reserved accesses are rejected separately.
  function automatic logic [2:0] acc_bytes(input logic [1:0] s);
    unique case (s)
      ACC_WORD: acc_bytes = 3'd4;
      ACC_HALF: acc_bytes = 3'd2;
      default:  acc_bytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: big-endian lane steering for one aligned word.
// Ports: off_i/size_i/wdata_i in, rlane_i read bytes in,
// be_o/wlane_o write enables+lanes out, rdata_o packed read out.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]      off_i,
  input  logic [1:0]      size_i,
  input  logic [31:0]     wdata_i,
  input  logic [3:0][7:0] rlane_i,
  output logic [3:0]      be_o,
  output logic [3:0][7:0] wlane_o,
  output logic [31:0]     rdata_o
);

  // Lane k is the byte at aligned word address + k.
  always_comb begin
    be_o    = 4'b0000;
    wlane_o = '0;
    rdata_o = '0;
    unique case (size_i)
      ACC_WORD: begin
        be_o       = 4'b1111;
        wlane_o[0] = wdata_i[31:24];
        wlane_o[1] = wdata_i[23:16];
        wlane_o[2] = wdata_i[15:8];
        wlane_o[3] = wdata_i[7:0];
        rdata_o    = {rlane_i[0], rlane_i[1],
                      rlane_i[2], rlane_i[3]};
      end
      ACC_HALF: begin
        wlane_o[0] = wdata_i[15:8];
        wlane_o[1] = wdata_i[7:0];
        wlane_o[2] = wdata_i[15:8];
        wlane_o[3] = wdata_i[7:0];
        if (off_i[1]) begin
          be_o    = 4'b1100;
          rdata_o = {16'h0, rlane_i[2], rlane_i[3]};
        end else begin
          be_o    = 4'b0011;
          rdata_o = {16'h0, rlane_i[0], rlane_i[1]};
        end
      end
      ACC_BYTE: begin
        wlane_o = {4{wdata_i[7:0]}};
        be_o    = 4'b0001 << off_i;
        rdata_o = {24'h0, rlane_i[off_i]};
      end
      default: begin
        be_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/memory.sv
// memory: byte-addressable big-endian unified I/D store.
// Ports: clk, reset (async high), address, data_in, write,
// access_size in; data_out combinational zero-extended read.
module memory
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = MEM_BASE,
  parameter int unsigned DEPTH_BYTES = MEM_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic        write,
  input  logic [1:0]  access_size,
  output logic [31:0] data_out
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  logic [7:0]      mem_q [DEPTH_BYTES];
  logic [31:0]     off;
  logic [32:0]     last;
  logic            in_rng;
  logic            we;
  logic [3:0]      be;
  logic [3:0][7:0] wlane;
  logic [3:0][7:0] rlane;
  logic [31:0]     rdata;

  assign off  = address - BASE_ADDR;
  // 33 bits so offsets near 2^32 cannot wrap back into range.
  assign last = {1'b0, off}
              + 33'(acc_bytes(access_size))
              - 33'd1;

  assign in_rng = (address >= BASE_ADDR)
               && (last < 33'(DEPTH_BYTES))
               && (access_size != ACC_RSVD);

  assign we = write && !reset && in_rng;

  for (genvar k = 0; k < 4; k++) begin : g_rd
    assign rlane[k] = mem_q[{off[AW-1:2], 2'(k)}];
  end

  mem_lane_align u_align (
    .off_i   (off[1:0]),
    .size_i  (access_size),
    .wdata_i (data_in),
    .rlane_i (rlane),
    .be_o    (be),
    .wlane_o (wlane),
    .rdata_o (rdata)
  );

  assign data_out = in_rng ? rdata : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH_BYTES; i++)
        mem_q[AW'(i)] <= 8'h00;
    end else if (we) begin
      for (int k = 0; k < 4; k++)
        if (be[k])
          mem_q[{off[AW-1:2], 2'(k)}] <= wlane[k];
    end
  end

endmodule

// File: tb/tb_memory.sv
// tb_memory: directed + randomized checks of memory against
// a byte-array big-endian reference model.
module tb_memory;

  localparam logic [31:0] BASE  = 32'h8002_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        write;
  logic [1:0]  access_size;
  logic [31:0] data_out;

  int checks   = 0;
  int failures = 0;

  logic [7:0] ref_mem [DEPTH];

  memory #(.DEPTH_BYTES(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .data_in     (data_in),
    .write       (write),
    .access_size (access_size),
    .data_out    (data_out)
  );

  always #5 clk = ~clk;

  function automatic int nbytes(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_ok(input logic [31:0] a,
                              input logic [1:0] s);
    longint off;
    int n;
    n = nbytes(s);
    if (n == 0 || a < BASE) return 0;
    off = longint'(a - BASE);
    return (off + n - 1) < DEPTH;
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] a,
                                       input logic [1:0] s);
    int n, base;
    logic [31:0] v;
    if (!m_ok(a, s)) return 32'h0;
    n = nbytes(s);
    base = int'(a - BASE) / n * n;
    v = 0;
    for (int i = 0; i < n; i++)
      v = (v << 8) | 32'(ref_mem[base + i]);
    return v;
  endfunction

  task automatic m_wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s);
    int n, base;
    if (!m_ok(a, s)) return;
    n = nbytes(s);
    base = int'(a - BASE) / n * n;
    for (int i = 0; i < n; i++)
      ref_mem[base + i] = 8'(d >> (8 * (n - 1 - i)));
  endtask

  task automatic m_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle: drive after posedge, check at negedge against
  // the model (pre-write contents), then commit a write.
  task automatic cyc(input logic [31:0] a, input logic [31:0] d,
                     input logic w, input logic [1:0] s,
                     input string tag);
    @(posedge clk);
    #1;
    address = a; data_in = d; write = w; access_size = s;
    @(negedge clk);
    chk(tag, data_out, m_rd(a, s));
    if (w) m_wr(a, d, s);
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] s,
                    input logic [31:0] exp, input string tag);
    cyc(a, 32'h0, 1'b0, s, {tag, "_model"});
    chk(tag, data_out, exp);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [1:0]  s;
    logic        w;
    reset = 1'b1;
    address = BASE; data_in = 0; write = 0; access_size = 2'b10;
    m_clear();
    #3;
    chk("reset_state", data_out, 32'h0);
    #4 reset = 1'b0;

    cyc(BASE, 32'h9876_5432, 1'b1, 2'b10, "wr_word");
    rd(BASE,      2'b10, 32'h9876_5432, "rd_word");
    rd(BASE,      2'b01, 32'h0000_9876, "rd_half0");
    rd(BASE,      2'b00, 32'h0000_0098, "rd_byte0");
    rd(BASE + 3,  2'b00, 32'h0000_0032, "rd_byte3");
    rd(BASE + 2,  2'b01, 32'h0000_5432, "rd_half2");
    rd(BASE + 1,  2'b10, 32'h9876_5432, "rd_word_unal");

    cyc(BASE + 8, 32'h1234_AAAA, 1'b1, 2'b01, "wr_half");
    rd(BASE + 8,  2'b01, 32'h0000_AAAA, "rd_half");
    rd(BASE + 8,  2'b10, 32'hAAAA_0000, "rd_half_word");

    cyc(BASE + 12, 32'hFFFF_FFBB, 1'b1, 2'b00, "wr_byte");
    rd(BASE + 12, 2'b00, 32'h0000_00BB, "rd_byte");
    rd(BASE + 12, 2'b10, 32'hBB00_0000, "rd_byte_word");
    rd(BASE + 13, 2'b00, 32'h0000_0000, "nbr_after");
    rd(BASE + 11, 2'b00, 32'h0000_0000, "nbr_before");

    cyc(32'h8001_FFFC, 32'hDEAD_BEEF, 1'b1, 2'b10, "wr_low");
    rd(32'h8001_FFFC, 2'b10, 32'h0, "rd_low");
    rd(BASE, 2'b10, 32'h9876_5432, "low_no_alias");
    cyc(BASE + 16, 32'hCAFE_F00D, 1'b1, 2'b11, "wr_rsvd");
    rd(BASE + 16, 2'b10, 32'h0, "rsvd_dropped");
    rd(BASE, 2'b11, 32'h0, "rd_rsvd");

    cyc(BASE + DEPTH - 4, 32'h0102_0304, 1'b1, 2'b10, "wr_top");
    rd(BASE + DEPTH - 4, 2'b10, 32'h0102_0304, "rd_top");
    rd(BASE + DEPTH - 1, 2'b00, 32'h0000_0004, "rd_top_b");
    rd(BASE + DEPTH, 2'b00, 32'h0, "rd_past_top");
    rd(BASE + DEPTH - 2, 2'b10, 32'h0, "rd_top_straddle");

    // write/read same location: old value, then new
    cyc(BASE, 32'h1111_2222, 1'b1, 2'b10, "rw_same_old");
    chk("rw_same_oldc", data_out, 32'h9876_5432);
    rd(BASE, 2'b10, 32'h1111_2222, "rw_same_new");

    for (int i = 0; i < 400; i++) begin
      s = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      case ($urandom_range(0, 9))
        0:       a = BASE - 32'($urandom_range(1, 8));
        1:       a = BASE + 32'($urandom_range(DEPTH - 6, DEPTH + 4));
        default: a = BASE + 32'($urandom_range(0, 63));
      endcase
      cyc(a, d, w, s, "rand");
    end

    // async reset between edges; pending write must be aborted
    cyc(BASE + 20, 32'h5555_6666, 1'b1, 2'b10, "pre_rst_wr");
    rd(BASE + 20, 2'b10, 32'h5555_6666, "pre_rst_rd");
    @(posedge clk);
    #1;
    address = BASE + 20; data_in = 32'h7777_8888;
    write = 1'b1; access_size = 2'b10;
    #2 reset = 1'b1;
    #1 chk("async_rst", data_out, 32'h0);
    m_clear();
    @(posedge clk);
    #3 write = 1'b0;
    #4 reset = 1'b0;
    rd(BASE + 20, 2'b10, 32'h0, "rst_abort");
    rd(BASE + 4, 2'b10, 32'h0, "rst_clear");
    cyc(BASE + 24, 32'hABCD_EF01, 1'b1, 2'b10, "post_rst_wr");
    rd(BASE + 24, 2'b10, 32'hABCD_EF01, "post_rst_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory.md
# memory

Byte-addressable unified instruction/data memory for the ECE621 pipelined processor. It holds program text and data at a fixed base address and accepts byte, halfword and word accesses. Writes are synchronous; reads are combinational, so fetch and memory stages see data within the same cycle. It sits beside the pipeline and serves as the fetch/load/store backing store in simulation.

## Interface
- `BASE_ADDR`, default 32'h8002_0000: first byte address mapped to the array.
- `DEPTH_BYTES`, default 1048576: array size in bytes. Must be a multiple of 4.
- `clk`, input, 1: clock. All writes occur on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `address`, input, 32: byte address of the access.
- `data_in`, input, 32: write data. The byte sits in [7:0] and the halfword in [15:0].
- `write`, input, 1: 1 means write on the next rising edge; 0 means read.
- `access_size`, input, 2: access width. 00 is byte, 01 is halfword, 10 is word, 11 is reserved.
- `data_out`, output, 32: combinational read data, zero-extended.

## Operation
- Storage is a byte array `DEPTH_BYTES` long.
- Offset is `address - BASE_ADDR`. An address is in range when BASE_ADDR <= address and offset + size - 1 < DEPTH_BYTES.
- Byte order is big-endian, matching MIPS:
  - A word at offset o occupies bytes o..o+3, with byte o = data[31:24].
  - A halfword at o occupies bytes o..o+1, with byte o = data[15:8].
- Alignment: the low address bits are ignored for the access size.
  - Halfword uses address[0] = 0.
  - Word uses address[1:0] = 00.
  - No misalignment error is raised.
- Write, when `write`=1 and access_size is 00, 01 or 10:
  - Sampled on the rising edge of `clk`.
  - Only the addressed bytes change.
  - Upper bits of data_in are ignored for byte and halfword writes.
- Read, when `write`=0:
  - data_out = the addressed bytes, zero-extended to 32 bits.
  - Halfword read returns {16'h0, hw}.
  - Byte read returns {24'h0, b}.
- data_out follows address and access_size combinationally, independent of `write`.
  - While write=1, data_out shows the pre-write contents of the addressed location.
- Out-of-range address: writes are dropped and data_out = 0.
- access_size = 11: writes are dropped and data_out = 0.
- Reset:
  - Asserting `reset` clears every byte to 8'h00 immediately, without waiting for a clock.
  - data_out therefore reads 0 everywhere.
  - Writes are blocked while reset is high.
  - Deassertion needs no clock alignment. The first write is taken on the first rising edge with reset low.

## Timing
- Write latency is 1 edge. Data written at edge N is readable combinationally right after edge N.
- Read latency is 0 cycles, purely combinational from address and access_size to data_out.
- Bench convention:
  - Drive address, write and access_size after a rising edge, and data_in by the falling edge.
  - Sample data_out at the falling edge.
- A read and a write to the same location in the same cycle returns the old value until the edge, then the new one.
- Back-to-back writes on consecutive edges are fully supported. There is no busy state and no handshake.
- Reset asserted mid-cycle aborts a write pending for the next edge.

## Structure
- Shared package `mem_pkg`:
  - `ACC_BYTE`=2'b00, `ACC_HALF`=2'b01, `ACC_WORD`=2'b10.
  - `MEM_BASE`=32'h8002_0000 and the default depth.
- One sub-module, `mem_lane_align`. It is combinational and takes offset, access_size and data_in.
  - It produces per-byte write enables and big-endian byte lanes.
  - It also packs and zero-extends the read bytes.
- Top level holds the byte array, range check, reset clear and write process.

## Test plan
- Word round trip: write 0x98765432 to 0x80020000 with size 10, then read with size 10. data_out must be 0x98765432.
- Subword reads of that word at 0x80020000:
  - size 01 must give 0x00009876.
  - size 00 must give 0x00000098.
  - A byte read at 0x80020003 must give 0x00000032.
- Halfword write 0xAAAA at 0x80020008 with size 01, then halfword read must give 0x0000AAAA.
  - A word read there must give 0xAAAA0000, with other bytes still 0 after reset.
- Byte write 0xBB at 0x8002000C with size 00, then byte read must give 0x000000BB.
  - A word read at 0x8002000C must give 0xBB000000.
  - Neighbouring bytes must be unchanged.
- Reset and range:
  - Assert reset asynchronously between edges. A word read at 0x80020000 must return 0 before the next edge.
  - A write to 0x8001FFFC is dropped, and a read there must give 0.
  - A write with size 11 is dropped.
